// File: rtl/signal_light_mon.sv
// Passive checker for the two-road signal-light interface: decodes the phase,
// flags encoding/conflict/order/duration errors and reports phase statistics.
// Optional count continuity checker: define SIGNAL_LIGHT_MON_COUNT_CHK_EN.
module signal_light_mon #(
    parameter int unsigned GREEN_LEN  = 25,
    parameter int unsigned YELLOW_LEN = 5,
    parameter int unsigned TOL        = 1,
    parameter int unsigned CNT_MOD    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light1,
    input  logic [2:0] light2,
    input  logic [5:0] count,
    input  logic       err_clr,
    output logic [2:0] phase,
    output logic       locked,
    output logic [4:0] err,
    output logic       err_any,
    output logic [6:0] last_dur,
    output logic [7:0] cycle_cnt
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [6:0] TOL7 = 7'(TOL);
    localparam logic [6:0] DUR_MAX = 7'd127;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } phase_e;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic phase_e succ(input phase_e p);
        phase_e n;
        case (p)
            PH1:     n = PH2;
            PH2:     n = PH3;
            PH3:     n = PH4;
            PH4:     n = PH1;
            default: n = SYNC;
        endcase
        return n;
    endfunction

    // Compare in 9 bits so LEN+TOL cannot wrap and LEN-TOL is never formed.
    function automatic logic dur_in_range(input logic [6:0] d, input logic green);
        logic [8:0] len;
        logic [8:0] dw;
        logic [8:0] tw;
        len = green ? 9'(GREEN_LEN) : 9'(YELLOW_LEN);
        dw  = {2'b00, d};
        tw  = {2'b00, TOL7};
        return ((dw + tw) >= len) && (dw <= (len + tw));
    endfunction

    phase_e     phase_q, phase_d;
    logic       locked_q, locked_d;
    logic [4:0] err_q, err_d;
    logic       err_any_q, err_any_d;
    logic [6:0] last_dur_q, last_dur_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0] prev1_q, prev2_q;
    logic [6:0] dur_q, dur_d;
    logic       first_q, first_d;

    logic       enc_ok;
    logic       is_startup;
    logic       conflict;
    logic       same;
    logic       cnt_err;
    phase_e     samp_ph;
    logic [4:0] new_err;

    always_comb begin
        enc_ok     = is_onehot(light1) && is_onehot(light2);
        is_startup = (light1 == YEL) && (light2 == YEL);
        case ({light1, light2})
            {RED, GRN}: samp_ph = PH1;
            {RED, YEL}: samp_ph = PH2;
            {GRN, RED}: samp_ph = PH3;
            {YEL, RED}: samp_ph = PH4;
            default:    samp_ph = SYNC;
        endcase
        conflict = enc_ok &&
                   (((light1 != RED) && (light2 != RED) && !is_startup) ||
                    (is_startup && (phase_q != SYNC)));
        same = (light1 == prev1_q) && (light2 == prev2_q);
    end

`ifdef SIGNAL_LIGHT_MON_COUNT_CHK_EN
    logic [5:0] prev_cnt_q;
    logic       cnt_vld_q;
    logic [5:0] cnt_exp;

    always_comb begin
        cnt_exp = (prev_cnt_q == 6'(CNT_MOD - 1)) ? 6'd0 : prev_cnt_q + 6'd1;
        cnt_err = cnt_vld_q && (count != cnt_exp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt_q <= 6'd0;
            cnt_vld_q  <= 1'b0;
        end else begin
            prev_cnt_q <= count;
            cnt_vld_q  <= 1'b1;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^count;
    assign cnt_err      = 1'b0;
`endif

    always_comb begin
        phase_d     = phase_q;
        dur_d       = dur_q;
        first_d     = first_q;
        last_dur_d  = last_dur_q;
        cycle_cnt_d = cycle_cnt_q;
        new_err     = 5'b00000;
        new_err[4]  = cnt_err;

        if (!enc_ok) begin
            new_err[0] = 1'b1;
            phase_d    = SYNC;
        end else if (conflict) begin
            new_err[1] = 1'b1;
            phase_d    = SYNC;
        end else if (phase_q == SYNC) begin
            if (samp_ph != SYNC) begin
                phase_d = samp_ph;
                first_d = 1'b1;
                dur_d   = 7'd1;
            end
        end else if (same) begin
            dur_d = (dur_q == DUR_MAX) ? dur_q : dur_q + 7'd1;
        end else if ((samp_ph != SYNC) && (samp_ph == succ(phase_q))) begin
            // The phase seen right after locking started mid-way, so skip it.
            if (!first_q) begin
                last_dur_d = dur_q;
                if (!dur_in_range(dur_q, (phase_q == PH1) || (phase_q == PH3)))
                    new_err[3] = 1'b1;
            end
            if (phase_q == PH4)
                cycle_cnt_d = cycle_cnt_q + 8'd1;
            first_d = 1'b0;
            dur_d   = 7'd1;
            phase_d = samp_ph;
        end else begin
            new_err[2] = 1'b1;
            phase_d    = SYNC;
        end

        err_d     = (err_clr ? 5'b00000 : err_q) | new_err;
        err_any_d = |err_d;
        locked_d  = (phase_d != SYNC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= SYNC;
            locked_q    <= 1'b0;
            err_q       <= 5'b00000;
            err_any_q   <= 1'b0;
            last_dur_q  <= 7'd0;
            cycle_cnt_q <= 8'd0;
            prev1_q     <= 3'b000;
            prev2_q     <= 3'b000;
            dur_q       <= 7'd0;
            first_q     <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_any_q   <= err_any_d;
            last_dur_q  <= last_dur_d;
            cycle_cnt_q <= cycle_cnt_d;
            prev1_q     <= light1;
            prev2_q     <= light2;
            dur_q       <= dur_d;
            first_q     <= first_d;
        end
    end

    assign phase     = phase_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_any   = err_any_q;
    assign last_dur  = last_dur_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_signal_light_mon.sv
// Scoreboard bench for signal_light_mon: a pattern-level reference model pushes
// expected outputs per sample; a monitor pops and compares after each edge.
module tb_signal_light_mon;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int GL = 25;
    localparam int YL = 5;
    localparam int TL = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light1 = R;
    logic [2:0] light2 = R;
    logic [5:0] count = 6'd0;
    logic       err_clr = 1'b0;
    logic [2:0] phase;
    logic       locked;
    logic [4:0] err;
    logic       err_any;
    logic [6:0] last_dur;
    logic [7:0] cycle_cnt;

    signal_light_mon #(.GREEN_LEN(GL), .YELLOW_LEN(YL), .TOL(TL), .CNT_MOD(60)) dut (
        .clk(clk), .rst_n(rst_n), .light1(light1), .light2(light2), .count(count),
        .err_clr(err_clr), .phase(phase), .locked(locked), .err(err),
        .err_any(err_any), .last_dur(last_dur), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int lk;
        int er;
        int ea;
        int ld;
        int cc;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    int m_ph, m_run, m_first, m_last, m_cyc, m_err, m_cprev, m_cvld;
    int cnt_cur = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ph = 0; m_run = 0; m_first = 0; m_last = 0;
        m_cyc = 0; m_err = 0; m_cprev = 0; m_cvld = 0;
    endtask

    // 0 bad encoding, 1..4 phases, 5 startup, 6 red/red, 7 other conflict
    function automatic int classify(input logic [2:0] a, input logic [2:0] b);
        if ($countones(a) != 1 || $countones(b) != 1) return 0;
        if (a == R && b == G) return 1;
        if (a == R && b == Y) return 2;
        if (a == G && b == R) return 3;
        if (a == Y && b == R) return 4;
        if (a == Y && b == Y) return 5;
        if (a == R && b == R) return 6;
        return 7;
    endfunction

    function automatic logic [5:0] codes(input int pat);
        case (pat)
            1: return {R, G};
            2: return {R, Y};
            3: return {G, R};
            4: return {Y, R};
            5: return {Y, Y};
            6: return {R, R};
            default: return {G, G};
        endcase
    endfunction

    task automatic step(input logic [2:0] l1, input logic [2:0] l2,
                        input bit clr = 1'b0, input int cjump = 1);
        int pat, nerr, len;
        exp_t e;
        @(negedge clk);
        light1 = l1; light2 = l2; err_clr = clr; count = 6'(cnt_cur);
        pat = classify(l1, l2);
        nerr = 0;
        if (pat == 0) begin
            nerr |= 1; m_ph = 0;
        end else if (pat == 7 || (pat == 5 && m_ph != 0)) begin
            nerr |= 2; m_ph = 0;
        end else if (m_ph == 0) begin
            if (pat >= 1 && pat <= 4) begin
                m_ph = pat; m_first = 1; m_run = 1;
            end
        end else if (pat == m_ph) begin
            m_run = (m_run >= 127) ? 127 : m_run + 1;
        end else if (pat == (m_ph % 4) + 1) begin
            if (m_first == 0) begin
                m_last = m_run;
                len = (m_ph == 1 || m_ph == 3) ? GL : YL;
                if (m_run < len - TL || m_run > len + TL) nerr |= 8;
            end
            if (m_ph == 4) m_cyc = (m_cyc + 1) % 256;
            m_first = 0; m_ph = pat; m_run = 1;
        end else begin
            nerr |= 4; m_ph = 0;
        end
`ifdef SIGNAL_LIGHT_MON_COUNT_CHK_EN
        if (m_cvld != 0 && cnt_cur != (m_cprev + 1) % 60) nerr |= 16;
`endif
        m_cprev = cnt_cur; m_cvld = 1;
        m_err = (clr ? 0 : m_err) | nerr;
        e.ph = m_ph; e.lk = (m_ph != 0); e.er = m_err; e.ea = (m_err != 0);
        e.ld = m_last; e.cc = m_cyc;
        sb.push_back(e);
        cnt_cur = (cnt_cur + cjump) % 60;
    endtask

    task automatic send(input int pat, input int n);
        logic [5:0] c;
        c = codes(pat);
        for (int i = 0; i < n; i++) step(c[5:3], c[2:0]);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_any"}, err_any, 0);
        chk({tag, "_last_dur"}, last_dur, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_phase", phase, e.ph);
            chk("sb_locked", locked, e.lk);
            chk("sb_err", err, e.er);
            chk("sb_err_any", err_any, e.ea);
            chk("sb_last_dur", last_dur, e.ld);
            chk("sb_cycle_cnt", cycle_cnt, e.cc);
        end
    end

    initial begin
        int cur, r, len;
        logic [5:0] c;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        #3 rst_n = 1'b1;

        // legal run
        send(5, 3); send(1, 25); send(2, 5); send(3, 25); send(4, 5); send(1, 1);
        settle();
        chk("legal_cycle_cnt", cycle_cnt, 1);
        chk("legal_last_dur_p4", last_dur, 5);
        chk("legal_phase_p1", phase, 1);
        send(1, 24); send(2, 1);
        settle();
        chk("legal_last_dur_p1", last_dur, 25);
        chk("legal_err", err, 0);

        // duration error: P2 held 8
        send(2, 7); send(3, 1);
        settle();
        chk("dur_err", err, 8);
        chk("dur_last_dur", last_dur, 8);
        chk("dur_phase", phase, 3);

        // order error then relock
        send(3, 24); send(4, 5); send(1, 3); send(3, 1);
        settle();
        chk("order_err", err, 12);
        chk("order_phase", phase, 0);
        send(3, 1);
        settle();
        chk("relock_phase", phase, 3);

        // conflict
        send(7, 1);
        settle();
        chk("conflict_err", err, 14);
        chk("conflict_phase", phase, 0);

        // encoding error with simultaneous clear
        step(3'b011, R, 1'b1);
        settle();
        chk("clr_enc_err", err, 1);
        chk("enc_phase", phase, 0);
        chk("enc_err_any", err_any, 1);

        // count skip 41 -> 43
        cnt_cur = 41;
        step(R, R, 1'b0, 2);
        step(R, R, 1'b1);
        settle();
`ifdef SIGNAL_LIGHT_MON_COUNT_CHK_EN
        chk("count_skip_err", err, 16);
`else
        chk("count_skip_err", err, 0);
`endif

        // asynchronous reset in the middle of P3
        send(3, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(3, 10); send(4, 1);
        settle();
        chk("partial_last_dur", last_dur, 0);
        chk("partial_phase", phase, 4);
        chk("partial_err", err, 0);
        send(4, 4); send(1, 1);
        settle();
        chk("post_rst_last_dur", last_dur, 5);
        chk("post_rst_cycle_cnt", cycle_cnt, 1);

        // randomized traffic
        cur = 1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 78) begin
                cur = cur % 4 + 1;
                len = ((cur % 2) == 1 ? GL : YL) + $urandom_range(0, 4) - 2;
                send(cur, len);
            end else if (r < 84) begin
                step(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
            end else if (r < 88) begin
                send(5, 2);
            end else if (r < 92) begin
                send(6, 1);
            end else if (r < 96) begin
                c = codes(cur);
                step(c[5:3], c[2:0], 1'b1);
            end else begin
                c = codes(cur);
                step(c[5:3], c[2:0], 1'b0, 3);
            end
        end

        repeat (3) @(posedge clk);
        #3 chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
